// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Iterative multiply/divide unit beside the execute-stage ALU. Owns the HI/LO
//   pair and runs MULT/MULTU/DIV/DIVU with one shared 32-step datapath:
//   shift-add for multiply, restoring division for divide. Signed operations
//   run on magnitudes and get their sign fixed in a final one-cycle step.
//
// Ports
//   i_clk           clock, rising edge
//   i_reset_n       asynchronous active-low reset
//   i_start         request valid from execute
//   i_op            00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   i_data_A        multiplicand / dividend
//   i_data_B        multiplier / divisor
//   i_hilo_read     MFHI/MFLO in execute this cycle
//   i_flush         cancel the running operation
//   o_busy          an operation is in flight
//   o_stall         request or HI/LO read collides with a running operation
//   o_done          one-cycle pulse, HI/LO just updated
//   o_div_by_zero   one-cycle pulse alongside o_done for a zero divisor
//   o_hi, o_lo      HI / LO registers
module muldiv_sequencer #(
    parameter int NB_DATA = 32
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_start,
    input  logic [1:0]         i_op,
    input  logic [NB_DATA-1:0] i_data_A,
    input  logic [NB_DATA-1:0] i_data_B,
    input  logic               i_hilo_read,
    input  logic               i_flush,
    output logic               o_busy,
    output logic               o_stall,
    output logic               o_done,
    output logic               o_div_by_zero,
    output logic [NB_DATA-1:0] o_hi,
    output logic [NB_DATA-1:0] o_lo
);

    localparam int CNT_W  = $clog2(NB_DATA);
    localparam int NB_PROD = 2 * NB_DATA;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NB_DATA-1:0] hi_q, hi_d;
    logic [NB_DATA-1:0] lo_q, lo_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    // Datapath: acc = upper accumulator (mult) / partial remainder (div),
    // mq = multiplier (mult) / dividend shifting into quotient (div),
    // opnd = multiplicand (mult) / divisor (div); all held as magnitudes.
    logic [NB_DATA-1:0] acc_q, acc_d;
    logic [NB_DATA-1:0] mq_q, mq_d;
    logic [NB_DATA-1:0] opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;

    logic               start_signed;
    logic [NB_DATA:0]   mult_sum;
    logic [NB_DATA:0]   rem_sh;
    logic               trial_ok;
    logic [NB_DATA-1:0] trial_diff;
    logic [NB_PROD-1:0] product;
    logic [NB_DATA-1:0] quot_fixed;
    logic [NB_DATA-1:0] rem_fixed;

    function automatic logic [NB_DATA-1:0] magnitude(input logic signed [NB_DATA-1:0] v,
                                                     input logic is_signed);
        // 0x80000000 maps to itself, which read unsigned is the correct 2^31.
        return (is_signed && v[NB_DATA-1]) ? -v : v;
    endfunction

    function automatic logic [NB_DATA-1:0] neg_word(input logic signed [NB_DATA-1:0] v,
                                                    input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [NB_PROD-1:0] neg_dword(input logic signed [NB_PROD-1:0] v,
                                                     input logic neg);
        return neg ? -v : v;
    endfunction

    assign o_busy        = (state_q != ST_IDLE);
    assign o_stall       = (i_start | i_hilo_read) & o_busy;
    assign o_done        = done_q;
    assign o_div_by_zero = dbz_q;
    assign o_hi          = hi_q;
    assign o_lo          = lo_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;
        acc_d     = acc_q;
        mq_d      = mq_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;

        start_signed = ~i_op[0];

        // Multiply step: add multiplicand when multiplier LSB is set, keeping
        // the carry so the following right shift brings it into the top bit.
        mult_sum = {1'b0, acc_q} + {1'b0, (mq_q[0] ? opnd_q : '0)};

        // Divide step: remainder shifted left picks up the next dividend bit.
        // The true difference is below the divisor, so 32 bits hold it.
        rem_sh     = {acc_q, mq_q[NB_DATA-1]};
        trial_ok   = (rem_sh >= {1'b0, opnd_q});
        trial_diff = rem_sh[NB_DATA-1:0] - opnd_q;

        product    = neg_dword({acc_q, mq_q}, neg_res_q);
        quot_fixed = neg_word(mq_q, neg_res_q);
        rem_fixed  = neg_word(acc_q, neg_rem_q);

        case (state_q)
            ST_IDLE: begin
                if (i_start && !i_flush) begin
                    if (i_op[1] && (i_data_B == '0)) begin
                        hi_d   = i_data_A;
                        lo_d   = '1;
                        done_d = 1'b1;
                        dbz_d  = 1'b1;
                    end else begin
                        state_d   = ST_CALC;
                        cnt_d     = '0;
                        acc_d     = '0;
                        is_div_d  = i_op[1];
                        neg_res_d = start_signed & (i_data_A[NB_DATA-1] ^ i_data_B[NB_DATA-1]);
                        neg_rem_d = start_signed & i_data_A[NB_DATA-1];
                        if (i_op[1]) begin
                            mq_d   = magnitude(i_data_A, start_signed);
                            opnd_d = magnitude(i_data_B, start_signed);
                        end else begin
                            mq_d   = magnitude(i_data_B, start_signed);
                            opnd_d = magnitude(i_data_A, start_signed);
                        end
                    end
                end
            end

            ST_CALC: begin
                if (i_flush) begin
                    state_d = ST_IDLE;
                end else begin
                    if (!is_div_q) begin
                        acc_d = mult_sum[NB_DATA:1];
                        mq_d  = {mult_sum[0], mq_q[NB_DATA-1:1]};
                    end else if (trial_ok) begin
                        acc_d = trial_diff;
                        mq_d  = {mq_q[NB_DATA-2:0], 1'b1};
                    end else begin
                        acc_d = rem_sh[NB_DATA-1:0];
                        mq_d  = {mq_q[NB_DATA-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(NB_DATA - 1)) begin
                        state_d = ST_FIX;
                    end
                end
            end

            ST_FIX: begin
                state_d = ST_IDLE;
                if (!i_flush) begin
                    if (is_div_q) begin
                        hi_d = rem_fixed;
                        lo_d = quot_fixed;
                    end else begin
                        hi_d = product[NB_PROD-1:NB_DATA];
                        lo_d = product[NB_DATA-1:0];
                    end
                    done_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    // Working registers are always loaded before use, so they need no reset.
    always_ff @(posedge i_clk) begin
        acc_q     <= acc_d;
        mq_q      <= mq_d;
        opnd_q    <= opnd_d;
        is_div_q  <= is_div_d;
        neg_res_q <= neg_res_d;
        neg_rem_q <= neg_rem_d;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multiply/divide controller that sits beside the execute stage ALU and owns the HI/LO register pair. It accepts MULT/MULTU/DIV/DIVU requests from execute and runs a 32-step shift-add or restoring-divide sequence. It stalls the pipeline while a new request or a HI/LO read collides with a running operation. One shared iterative datapath serves all four operations.

## Interface
- NB_DATA, 32, operand/result width; iteration count equals NB_DATA

Ports:
- i_clk  in  1  clock, all state updates on rising edge
- i_reset_n  in  1  reset, asynchronous and active-low
- i_start  in  1  request valid from execute (opcode decoded as mult/div)
- i_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- i_data_A  in  NB_DATA  rs value after forwarding (multiplicand / dividend)
- i_data_B  in  NB_DATA  rt value after forwarding (multiplier / divisor)
- i_hilo_read  in  1  MFHI/MFLO in execute this cycle
- i_flush  in  1  cancel the running operation
- o_busy  out  1  state ≠ IDLE (combinational from state)
- o_stall  out  1  (i_start | i_hilo_read) & o_busy, combinational
- o_done  out  1  one-cycle pulse, HI/LO just updated
- o_div_by_zero  out  1  one-cycle pulse together with o_done
- o_hi  out  NB_DATA  HI register
- o_lo  out  NB_DATA  LO register

## Operation
- States: IDLE, CALC, FIX.
- IDLE: i_start & ~i_flush at the edge latches the operands as magnitudes for signed ops, records the result sign(s), clears the counter, and moves to CALC.
- DIV/DIVU with i_data_B == 0 skips CALC. The next edge writes o_hi = i_data_A and o_lo = all ones, pulses o_done and o_div_by_zero, and stays in IDLE.
- CALC, multiply: per edge, if multiplier LSB is 1 the upper accumulator adds the multiplicand (33-bit carry kept). The 64-bit {acc, multiplier} pair then shifts right one bit.
- CALC, divide: per edge, shift {rem, quot} left one bit and trial-subtract the divisor from rem. On no borrow, keep the difference and set the quot LSB. On borrow, restore.
- CALC lasts exactly NB_DATA edges (counter 0..NB_DATA-1), then goes to FIX.
- FIX (one edge) applies the sign fix:
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Unsigned ops pass through unchanged.
  - Then o_hi/o_lo are written (mult: hi = product[63:32], lo = product[31:0]; div: hi = remainder, lo = quotient), o_done pulses, and the state returns to IDLE.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF yields lo = 0x80000000, hi = 0 (wrap, no flag).
- i_start while busy is ignored. The requester holds via o_stall and re-presents the request, which is accepted on the edge where the state is IDLE.
- i_flush: any state → IDLE on the next edge. o_hi/o_lo are unchanged and o_done stays 0.
- i_flush has priority over i_start in the same cycle; the start is dropped.
- o_done/o_div_by_zero are registered and cleared on every edge on which they are not being set.

## Timing
- Reset (async assert, any state): state IDLE, counter 0, o_hi = o_lo = 0, o_done = o_div_by_zero = 0. Hence o_busy = o_stall = 0.
- Start sampled at edge k: CALC during edges k+1..k+NB_DATA, FIX at edge k+NB_DATA+1. o_done is high for the cycle following that edge (34 cycles after start for NB_DATA = 32).
- o_busy is high from edge k through edge k+NB_DATA+1 (low in the o_done cycle). A back-to-back start in the o_done cycle is accepted without a stall.
- Divide-by-zero: o_done high in the cycle after edge k; o_busy never rises.
- o_stall is purely combinational, so execute must not advance in a cycle where it is high.
- The HI/LO values read while o_done = 1 are the new results.
- Reset mid-CALC: the partial result is discarded and o_hi/o_lo go to 0 immediately (async).

## Test plan
- MULTU 0xFFFFFFFF × 2 -> o_done 34 cycles after start, o_hi = 0x00000001, o_lo = 0xFFFFFFFE, o_busy high exactly 34 edges.
- MULT -3 × 5 -> o_hi = 0xFFFFFFFF, o_lo = 0xFFFFFFF1. Immediately issue DIV -7 / 2 in the o_done cycle -> no stall, o_lo = 0xFFFFFFFD, o_hi = 0xFFFFFFFF.
- DIVU 5 / 0 -> o_done and o_div_by_zero high 1 cycle after start, o_hi = 5, o_lo = 0xFFFFFFFF, o_busy stays 0.
- Start DIVU 100 / 7, then i_hilo_read and a second i_start during CALC -> o_stall = 1 each such cycle. Final o_lo = 14, o_hi = 2. The held second request starts in the o_done cycle.
- Start MULT, assert i_flush at CALC iteration 10 -> IDLE next edge, o_hi/o_lo hold previous values, no o_done. Flush together with start in IDLE -> start dropped.
- Preload HI/LO via a completed op, start a new op, pulse i_reset_n low mid-CALC (between edges) -> all outputs 0 immediately, IDLE after release. DIV 0x80000000 / -1 -> o_lo = 0x80000000, o_hi = 0.
